// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Bundles the CPU-side request/response signals and the memory-side
//   request/acknowledge signals of the data-memory responder.
//   modport slave  : the responder (receives CPU requests, drives memory side)
//   modport master : the CPU + memory environment that talks to the responder
//   CPU side   : valid, op, addr, write_type, w_data_CPU, is_atom, signed_ext,
//                llbit_clear -> ; <- data_valid, r_data_CPU, cache_badv,
//                cache_exception
//   Memory side: <- mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata ;
//                mem_ack, mem_rdata ->
interface dmem_responder_if;
  logic        valid;
  logic        op;
  logic [31:0] addr;
  logic [3:0]  write_type;
  logic [31:0] w_data_CPU;
  logic        is_atom;
  logic        signed_ext;
  logic        llbit_clear;

  logic        data_valid;
  logic [31:0] r_data_CPU;
  logic [31:0] cache_badv;
  logic [6:0]  cache_exception;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  valid, op, addr, write_type, w_data_CPU, is_atom, signed_ext,
           llbit_clear, mem_ack, mem_rdata,
    output data_valid, r_data_CPU, cache_badv, cache_exception,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output valid, op, addr, write_type, w_data_CPU, is_atom, signed_ext,
           llbit_clear, mem_ack, mem_rdata,
    input  data_valid, r_data_CPU, cache_badv, cache_exception,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Accepts one CPU load/store (including LL/SC) at a time, checks alignment
//   and the LL reservation, issues a single word-aligned memory request with
//   lane-shifted strobes/data, and returns a one-cycle completion or
//   address-misaligned exception pulse.
//   Ports:
//     clk  : system clock, rising edge
//     rstn : asynchronous active-low reset
//     bus  : dmem_responder_if.slave (CPU request/response + memory side)
//
//   state  | meaning
//   IDLE   | waiting for valid; request captured here
//   WAIT   | mem_req held with latched request until mem_ack
//   DONE   | one-cycle data_valid or ALE exception pulse
module dmem_responder (
  input  logic             clk,
  input  logic             rstn,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic        op_q,     op_d;
  logic [31:0] addr_q,   addr_d;
  logic [3:0]  wtype_q,  wtype_d;
  logic [31:0] wdata_q,  wdata_d;
  logic        atom_q,   atom_d;
  logic        sext_q,   sext_d;
  logic [31:0] result_q, result_d;
  logic        llbit_q,  llbit_d;
  logic [29:0] lladdr_q, lladdr_d;

  function automatic logic misaligned(input logic [3:0] wt, input logic [1:0] lane);
    return ((wt == 4'b0011) && lane[0]) || ((wt == 4'b1111) && (lane != 2'b00));
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0]  wt,
                                              input logic        sext,
                                              input logic [31:0] word,
                                              input logic [1:0]  lane);
    logic [31:0] s;
    s = word >> {lane, 3'b000};
    case (wt)
      4'b0001: return sext ? {{24{s[7]}}, s[7:0]}   : {24'h0, s[7:0]};
      4'b0011: return sext ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      addr_q   <= 32'h0;
      wtype_q  <= 4'h0;
      wdata_q  <= 32'h0;
      atom_q   <= 1'b0;
      sext_q   <= 1'b0;
      result_q <= 32'h0;
      llbit_q  <= 1'b0;
      lladdr_q <= 30'h0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wtype_q  <= wtype_d;
      wdata_q  <= wdata_d;
      atom_q   <= atom_d;
      sext_q   <= sext_d;
      result_q <= result_d;
      llbit_q  <= llbit_d;
      lladdr_q <= lladdr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wtype_d  = wtype_q;
    wdata_d  = wdata_q;
    atom_d   = atom_q;
    sext_d   = sext_q;
    result_d = result_q;
    llbit_d  = llbit_q;
    lladdr_d = lladdr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          op_d     = bus.op;
          addr_d   = bus.addr;
          wtype_d  = bus.write_type;
          wdata_d  = bus.w_data_CPU;
          atom_d   = bus.is_atom;
          sext_d   = bus.signed_ext;
          result_d = 32'h0;
          if (misaligned(bus.write_type, bus.addr[1:0])) begin
            state_d = S_DONE;
          end else if (bus.op && bus.is_atom &&
                       (!llbit_q || (bus.addr[31:2] != lladdr_q))) begin
            // SC without a matching reservation completes locally with 0
            state_d = S_DONE;
            llbit_d = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          state_d = S_DONE;
          if (op_q) begin
            result_d = atom_q ? 32'h1 : 32'h0;
            if (atom_q) llbit_d = 1'b0;
          end else begin
            result_d = load_extend(wtype_q, sext_q, bus.mem_rdata, addr_q[1:0]);
            if (atom_q) begin
              llbit_d  = 1'b1;
              lladdr_d = addr_q[31:2];
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An exception/ERTN clear overrides any reservation set this cycle
    if (bus.llbit_clear) llbit_d = 1'b0;
  end

  logic in_wait;
  logic in_done;
  logic ale_done;

  assign in_wait  = (state_q == S_WAIT);
  assign in_done  = (state_q == S_DONE);
  assign ale_done = in_done && misaligned(wtype_q, addr_q[1:0]);

  assign bus.mem_req   = in_wait;
  assign bus.mem_we    = in_wait && op_q;
  assign bus.mem_addr  = in_wait ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wstrb = in_wait ? (wtype_q << addr_q[1:0]) : 4'h0;
  assign bus.mem_wdata = in_wait ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'h0;

  assign bus.data_valid      = in_done && !ale_done;
  assign bus.r_data_CPU      = (in_done && !ale_done) ? result_q : 32'h0;
  assign bus.cache_exception = {6'b000000, ale_done};
  assign bus.cache_badv      = ale_done ? addr_q : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [3:0]  wt;
    logic [31:0] wd;
    logic        atom;
    logic        sext;
    logic [31:0] rdata;
    int          dly;
    logic        mem;
    logic [3:0]  strb;
    logic [31:0] mwd;
    logic        exc;
    logic [31:0] res;
    int          clr;   // 0 none, 1 pulse before request, 2 held during request
    logic        b2b;   // issue straight after previous completion
    logic        drop;  // drop valid while waiting on memory
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;
  int   req_cnt = 0;
  logic req_seen = 1'b0;
  logic last_done = 1'b0;
  vec_t q[$];
  vec_t tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic op, logic [31:0] addr, logic [3:0] wt, logic [31:0] wd,
                              logic atom, logic sext, logic [31:0] rdata, int dly, logic mem,
                              logic [3:0] strb, logic [31:0] mwd, logic exc, logic [31:0] res,
                              int clr, logic b2b, logic drop);
    vec_t v;
    v.op = op; v.addr = addr; v.wt = wt; v.wd = wd; v.atom = atom; v.sext = sext;
    v.rdata = rdata; v.dly = dly; v.mem = mem; v.strb = strb; v.mwd = mwd; v.exc = exc;
    v.res = res; v.clr = clr; v.b2b = b2b; v.drop = drop;
    return v;
  endfunction

  // Memory model + scoreboard consumer, sampled on the falling edge
  always @(negedge clk) begin : mon
    vec_t e;
    if (!rstn) begin
      bus.mem_ack = 1'b0;
      req_cnt     = 0;
      req_seen    = 1'b0;
    end else begin
      if (bus.mem_req) begin
        if (q.size() == 0) begin
          check("spurious_mem_req", 32'd1, 32'd0);
          bus.mem_ack = 1'b0;
        end else begin
          e = q[0];
          req_seen = 1'b1;
          check("mem_we", {31'h0, bus.mem_we}, {31'h0, e.op});
          check("mem_addr", bus.mem_addr, {e.addr[31:2], 2'b00});
          if (e.op) begin
            check("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, e.strb});
            check("mem_wdata", bus.mem_wdata, e.mwd);
          end
          bus.mem_ack   = (req_cnt == e.dly);
          bus.mem_rdata = e.rdata;
          req_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        req_cnt     = 0;
      end

      if (bus.data_valid || (bus.cache_exception != 7'h0)) begin
        if (q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("data_valid", {31'h0, bus.data_valid}, {31'h0, !e.exc});
          check("cache_exception", {25'h0, bus.cache_exception}, {31'h0, e.exc});
          check("r_data_CPU", bus.r_data_CPU, e.res);
          check("cache_badv", bus.cache_badv, e.exc ? e.addr : 32'h0);
          check("mem_accessed", {31'h0, req_seen}, {31'h0, e.mem});
          check("latency", cyc - start_cyc, e.mem ? (1 + e.dly) : 0);
        end
        req_seen = 1'b0;
        done_cnt++;
      end else begin
        check("r_data_idle_zero", bus.r_data_CPU, 32'h0);
        check("badv_idle_zero", bus.cache_badv, 32'h0);
      end
    end
  end

  task automatic idle(input int n);
    bus.valid       = 1'b0;
    bus.llbit_clear = 1'b0;
    last_done       = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input vec_t v);
    bus.op          = v.op;
    bus.addr        = v.addr;
    bus.write_type  = v.wt;
    bus.w_data_CPU  = v.wd;
    bus.is_atom     = v.atom;
    bus.signed_ext  = v.sext;
    bus.llbit_clear = (v.clr == 2);
    q.push_back(v);
    bus.valid       = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    int prev;
    int n;
    if (v.clr == 1) begin
      bus.valid       = 1'b0;
      bus.llbit_clear = 1'b1;
      @(negedge clk);
      bus.llbit_clear = 1'b0;
      last_done       = 1'b0;
    end
    prev = done_cnt;
    drive(v);
    // right after a DONE the responder spends one cycle returning to IDLE
    if (last_done) @(posedge clk);
    @(posedge clk);
    #1 start_cyc = cyc;
    n = 0;
    while (done_cnt == prev && n < 100) begin
      @(negedge clk);
      #1;
      n++;
      if (v.drop && n == 1) bus.valid = 1'b0;
    end
    if (done_cnt == prev) begin
      check("completion_timeout", 32'd1, 32'd0);
      q.delete();
    end
    bus.llbit_clear = 1'b0;
    last_done       = 1'b1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    vec_t v;
    bus.valid = 1'b0; bus.op = 1'b0; bus.addr = 32'h0; bus.write_type = 4'h0;
    bus.w_data_CPU = 32'h0; bus.is_atom = 1'b0; bus.signed_ext = 1'b0; bus.llbit_clear = 1'b0;

    // op addr wt wd atom sext rdata dly mem strb mwd exc res clr b2b drop
    tbl.push_back(mk(0, 32'h1003, 4'b0001, 32'h0,        0, 1, 32'h80FFFFFF, 0, 1, 4'h0, 32'h0,        0, 32'hFFFFFF80, 0, 0, 0));
    tbl.push_back(mk(1, 32'h2002, 4'b0011, 32'h0000BEEF, 0, 0, 32'h0,        3, 1, 4'hC, 32'hBEEF0000, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 32'h3001, 4'b1111, 32'h0,        0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 32'h4000, 4'b1111, 32'h0,        1, 0, 32'h12345678, 1, 1, 4'h0, 32'h0,        0, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk(1, 32'h4000, 4'b1111, 32'hCAFEF00D, 1, 0, 32'h0,        0, 1, 4'hF, 32'hCAFEF00D, 0, 32'h1,        0, 1, 0));
    tbl.push_back(mk(1, 32'h4000, 4'b1111, 32'hCAFEF00D, 1, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 32'h6002, 4'b0011, 32'h0,        0, 0, 32'h80011234, 2, 1, 4'h0, 32'h0,        0, 32'h00008001, 0, 0, 0));
    tbl.push_back(mk(0, 32'h6002, 4'b0011, 32'h0,        0, 1, 32'h80011234, 0, 1, 4'h0, 32'h0,        0, 32'hFFFF8001, 0, 1, 0));
    tbl.push_back(mk(0, 32'h7001, 4'b0001, 32'h0,        0, 0, 32'h1122A3F4, 0, 1, 4'h0, 32'h0,        0, 32'h000000A3, 0, 1, 0));
    tbl.push_back(mk(0, 32'h7000, 4'b0001, 32'h0,        0, 1, 32'h1122A3F4, 0, 1, 4'h0, 32'h0,        0, 32'hFFFFFFF4, 0, 1, 0));
    tbl.push_back(mk(1, 32'h7002, 4'b0001, 32'h000000AB, 0, 0, 32'h0,        1, 1, 4'h4, 32'h00AB0000, 0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 32'h2003, 4'b0011, 32'h0000BEEF, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        1, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 32'h6001, 4'b0011, 32'h0,        0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        1, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 32'h8000, 4'b1111, 32'h0,        0, 0, 32'hDEADBEEF, 3, 1, 4'h0, 32'h0,        0, 32'hDEADBEEF, 0, 0, 1));
    tbl.push_back(mk(1, 32'h8004, 4'b1111, 32'h01020304, 0, 0, 32'h0,        0, 1, 4'hF, 32'h01020304, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 32'h5000, 4'b1111, 32'h0,        1, 0, 32'h00000055, 0, 1, 4'h0, 32'h0,        0, 32'h00000055, 0, 0, 0));
    tbl.push_back(mk(1, 32'h5000, 4'b1111, 32'h11111111, 1, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 32'h0,        1, 0, 0));
    tbl.push_back(mk(0, 32'h5000, 4'b1111, 32'h0,        1, 0, 32'h00000066, 0, 1, 4'h0, 32'h0,        0, 32'h00000066, 2, 0, 0));
    tbl.push_back(mk(1, 32'h5000, 4'b1111, 32'h22222222, 1, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 32'h9000, 4'b1111, 32'h0,        1, 0, 32'h00000077, 0, 1, 4'h0, 32'h0,        0, 32'h00000077, 0, 0, 0));
    tbl.push_back(mk(1, 32'h9004, 4'b1111, 32'h33333333, 1, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 32'h9000, 4'b1111, 32'h33333333, 1, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 32'hA000, 4'b1111, 32'h0,        1, 0, 32'h00000088, 0, 1, 4'h0, 32'h0,        0, 32'h00000088, 0, 0, 0));
    tbl.push_back(mk(1, 32'hA000, 4'b1111, 32'h5A5A5A5A, 1, 0, 32'h0,        0, 1, 4'hF, 32'h5A5A5A5A, 0, 32'h1,        0, 1, 0));

    // reset state, sampled between edges while rstn is low
    #12;
    check("rst_mem_req",    {31'h0, bus.mem_req},    32'h0);
    check("rst_mem_we",     {31'h0, bus.mem_we},     32'h0);
    check("rst_mem_addr",   bus.mem_addr,            32'h0);
    check("rst_mem_wstrb",  {28'h0, bus.mem_wstrb},  32'h0);
    check("rst_mem_wdata",  bus.mem_wdata,           32'h0);
    check("rst_data_valid", {31'h0, bus.data_valid}, 32'h0);
    check("rst_r_data",     bus.r_data_CPU,          32'h0);
    check("rst_exception",  {25'h0, bus.cache_exception}, 32'h0);
    check("rst_badv",       bus.cache_badv,          32'h0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].b2b) idle(2);
      apply(tbl[i]);
    end

    // reset in the middle of a memory wait; reservation must not survive
    idle(2);
    apply(mk(0, 32'hB000, 4'b1111, 32'h0, 1, 0, 32'h00000099, 0, 1, 4'h0, 32'h0, 0, 32'h00000099, 0, 0, 0));
    idle(2);
    v = mk(0, 32'hC000, 4'b1111, 32'h0, 0, 0, 32'h0, 20, 1, 4'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("req_before_reset", {31'h0, bus.mem_req}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("req_async_drop",   {31'h0, bus.mem_req},    32'h0);
    check("we_async_drop",    {31'h0, bus.mem_we},     32'h0);
    check("addr_async_drop",  bus.mem_addr,            32'h0);
    check("dv_during_reset",  {31'h0, bus.data_valid}, 32'h0);
    q.delete();
    bus.valid = 1'b0;
    @(negedge clk);
    #1 rstn = 1'b1;
    last_done = 1'b0;
    apply(mk(1, 32'hB000, 4'b1111, 32'h44444444, 1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0, 0));
    idle(1);
    apply(mk(0, 32'hC000, 4'b1111, 32'h0, 0, 0, 32'h0BADF00D, 0, 1, 4'h0, 32'h0, 0, 32'h0BADF00D, 0, 0, 0));

    idle(3);
    check("scoreboard_empty", q.size(), 32'd0);
    check("completions", done_cnt, tbl.size() + 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
